// File: rtl/add_test_2_registered_adder.sv
// ---------------------------------------------------------------------------
// add_test_2_registered_adder
//
// Registered WIDTH-bit unsigned adder. The combinational sum is built from
// 4-bit carry-lookahead groups (per-bit generate/propagate, group G/P) whose
// group carries are chained from a carry-in of 0. The sum is captured on the
// rising clock edge, so results appear one edge after the operands.
// There are no input registers and no handshake.
//
// Reset: synchronous, active-low (rst_n), sampled only on the rising edge.
//
// Optional feature macro: ADD_CARRY_OUT_EN
//   defined   -> adds registered output carry_out (bit WIDTH of r1 + r2)
//   undefined -> no carry_out port or register; otherwise identical
//
// WIDTH must be a multiple of 4; 16 is the supported configuration.
// ---------------------------------------------------------------------------
module add_test_2_registered_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r_result_bus
`ifdef ADD_CARRY_OUT_EN
  ,
  output logic             carry_out
`endif
);

  localparam int NG = WIDTH / 4;

  // One 4-bit carry-lookahead group.
  // Returns {group_generate, group_propagate, sum[3:0]}.
  function automatic logic [5:0] cla4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       cin
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       gp;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
    return {gg, gp, p ^ c};
  endfunction

  logic [WIDTH-1:0] w_sum;
  logic [NG:0]      w_group_c;
  logic [5:0]       w_grp [NG];

  // Carry-lookahead sum: each group's carry-in comes from the previous
  // group's G/P and carry, starting from a carry-in of 0.
  always_comb begin
    w_sum        = {WIDTH{1'b0}};
    w_group_c    = {(NG+1){1'b0}};
    for (int k = 0; k < NG; k++) begin
      w_grp[k] = 6'b00_0000;
    end
    w_group_c[0] = 1'b0;
    for (int k = 0; k < NG; k++) begin
      w_grp[k]        = cla4(r1[4*k +: 4], r2[4*k +: 4], w_group_c[k]);
      w_sum[4*k +: 4] = w_grp[k][3:0];
      w_group_c[k+1]  = w_grp[k][5] | (w_grp[k][4] & w_group_c[k]);
    end
  end

  // Result register: reset clears, otherwise capture the wrapped sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result_bus <= {WIDTH{1'b0}};
    end else begin
      r_result_bus <= w_sum;
    end
  end

`ifdef ADD_CARRY_OUT_EN
  // Carry-out register, updated alongside the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_out <= 1'b0;
    end else begin
      carry_out <= w_group_c[NG];
    end
  end
`else
  // Final group carry is not exported in this build.
  logic w_unused_carry;
  assign w_unused_carry = w_group_c[NG];
`endif

endmodule

// File: tb/tb_add_test_2_registered_adder.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for add_test_2_registered_adder.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_add_test_2_registered_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] r1;
  logic [15:0] r2;
  logic [15:0] r_result_bus;
`ifdef ADD_CARRY_OUT_EN
  logic        carry_out;
`endif

  int checks;
  int errors;

  add_test_2_registered_adder #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r1           (r1),
    .r2           (r2),
    .r_result_bus (r_result_bus)
`ifdef ADD_CARRY_OUT_EN
    ,
    .carry_out    (carry_out)
`endif
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_sum(input string tag, input logic [15:0] exp);
    checks++;
    assert (r_result_bus === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, r_result_bus, exp);
    end
  endtask

  task automatic chk_carry(input string tag, input logic exp);
`ifdef ADD_CARRY_OUT_EN
    checks++;
    assert (carry_out === exp) else begin
      errors++;
      $error("FAIL %s carry: observed %0b expected %0b", tag, carry_out, exp);
    end
`else
    if (exp !== 1'bx && tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_step(input logic [15:0] a, input logic [15:0] b);
    r1 = a;
    r2 = b;
    edge_step();
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [16:0] full;
    checks = 0;
    errors = 0;

    // Reset for one edge with non-zero operands present
    rst_n = 1'b0;
    r1    = 16'd123;
    r2    = 16'd456;
    edge_step();
    chk_sum("reset", 16'd0);
    chk_carry("reset", 1'b0);
    rst_n = 1'b1;

    // First edge after deassertion loads a valid sum
    add_step(16'd2, 16'd4);
    chk_sum("2+4", 16'd6);
    chk_carry("2+4", 1'b0);

    // Overflow wrap
    add_step(16'd34952, 16'd34952);
    chk_sum("34952+34952", 16'd4368);
    chk_carry("34952+34952", 1'b1);

    // All-ones plus one ripples through every group
    add_step(16'd65535, 16'd1);
    chk_sum("65535+1", 16'd0);
    chk_carry("65535+1", 1'b1);

    // Input change without an edge must not disturb the output
    r1 = 16'd0;
    r2 = 16'd0;
    #2;
    chk_sum("hold_no_edge", 16'd0);
    chk_carry("hold_no_edge", 1'b1);
    edge_step();
    chk_sum("0+0", 16'd0);
    chk_carry("0+0", 1'b0);

    // Carries crossing group boundaries
    add_step(16'h00FF, 16'h0001);
    chk_sum("00FF+0001", 16'h0100);
    add_step(16'h0FFF, 16'h0001);
    chk_sum("0FFF+0001", 16'h1000);
    add_step(16'h7FFF, 16'h0001);
    chk_sum("7FFF+0001", 16'h8000);
    chk_carry("7FFF+0001", 1'b0);
    add_step(16'hAAAA, 16'h5555);
    chk_sum("AAAA+5555", 16'hFFFF);
    chk_carry("AAAA+5555", 1'b0);

    // Hold with a non-zero value: inputs change, no edge
    r1 = 16'd9;
    r2 = 16'd9;
    #3;
    chk_sum("hold_FFFF", 16'hFFFF);

    // Mid-stream reset discards the sum at that edge; no async response
    add_step(16'd1000, 16'd2000);
    chk_sum("1000+2000", 16'd3000);
    rst_n = 1'b0;
    r1    = 16'd5;
    r2    = 16'd5;
    #2;
    chk_sum("no_async_reset", 16'd3000);
    edge_step();
    chk_sum("reset_priority", 16'd0);
    chk_carry("reset_priority", 1'b0);
    rst_n = 1'b1;
    edge_step();
    chk_sum("post_reset_5+5", 16'd10);

    // Random pairs within range
    for (int i = 0; i < 10; i++) begin
      ra   = 16'($urandom_range(9999, 0));
      rb   = 16'($urandom_range(19999, 0));
      full = {1'b0, ra} + {1'b0, rb};
      add_step(ra, rb);
      chk_sum($sformatf("rand%0d_%0d+%0d", i, ra, rb), full[15:0]);
      chk_carry($sformatf("rand%0d", i), full[16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_test_2_registered_adder.md
ADD_TEST_2_REGISTERED_ADDER -- requirements
Module: add_test_2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits; only 16 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port r1, input, WIDTH bits: unsigned addend A.
REQ-005 The block SHALL have port r2, input, WIDTH bits: unsigned addend B.
REQ-006 The block SHALL have port r_result_bus, output, WIDTH bits: registered sum.
REQ-007 The block SHALL have port carry_out, output, 1 bit: registered carry out of bit WIDTH-1; present only when ADD_CARRY_OUT_EN is defined.

Function
REQ-008 The block SHALL, on each rising clk edge with rst_n=1, load r_result_bus with (r1 + r2) mod 2^WIDTH, using the r1/r2 values present at that edge.
REQ-009 The block SHALL have a latency of exactly one clock edge, with no input registers: the result SHALL be visible after the first rising edge following an input change.
REQ-010 The block SHALL hold r_result_bus between rising edges; input changes without a clock edge SHALL NOT alter the output.
REQ-011 The block SHALL implement the combinational sum as four 4-bit carry-lookahead groups (generate/propagate per bit, group G/P) chained by group carries, with carry-in 0.
REQ-012 The block SHALL compute the sum of each bit as p[i] XOR c[i], where p[i] = a[i] XOR b[i].
REQ-013 The block SHALL wrap on overflow, discarding bit WIDTH of the sum in r_result_bus; e.g. 34952 + 34952 SHALL yield 4368.
REQ-014 The block SHALL have no handshake: every rising edge produces a new result, with no valid/ready signals.
REQ-015 The block SHALL produce a result with no X propagation from internal nodes whenever r1 and r2 are fully driven.

Reset
REQ-016 The block SHALL clear r_result_bus to 0 (and carry_out to 0 when present) on a rising clk edge with rst_n=0.
REQ-017 Reset SHALL take priority over the add; a reset asserted mid-stream SHALL discard the sum computed at that edge.
REQ-018 The block SHALL NOT respond to rst_n between clock edges; there is no asynchronous path.
REQ-019 After reset deassertion, the first rising edge with rst_n=1 SHALL load a valid sum.

Configuration
REQ-020 When the macro ADD_CARRY_OUT_EN is defined, the block SHALL include port carry_out, registered alongside r_result_bus, equal to bit WIDTH of r1+r2.
REQ-021 When ADD_CARRY_OUT_EN is undefined, the block SHALL NOT have a carry_out port or register, and all other behaviour SHALL be identical.

Verification
REQ-022 The bench SHALL cover: rst_n=0 for one edge, then rst_n=1 -> r_result_bus=0 immediately after the reset edge.
REQ-023 The bench SHALL cover: r1=2, r2=4, one rising edge -> r_result_bus=6 (carry_out=0).
REQ-024 The bench SHALL cover: r1=34952, r2=34952, one edge -> r_result_bus=4368 (carry_out=1).
REQ-025 The bench SHALL cover: r1=65535, r2=1, one edge -> r_result_bus=0 (carry_out=1); then r1=0, r2=0 with no clock edge -> output still 0; after an edge -> 0 (carry_out=0).
REQ-026 The bench SHALL cover: r1=1000, r2=2000 loaded, then rst_n=0 at the next edge with r1=5, r2=5 -> r_result_bus=0, not 10.
REQ-027 The bench SHALL cover 10 random pairs (r1 < 10000, r2 < 20000), one edge each -> r_result_bus = r1+r2 exactly.
